stepper_phase_driver: RTL and testbench

- Consumes the 3-bit speed code from the speed controller (code n = n×10 laps per minute, 1..6).
- Drives the four stepper coil phases at that rate, in the selected direction.
- Sits between the speed controller and the coil driver pins.
- Internally: a 2-flop synchronizer, a reloadable step-interval down-counter, a phase sequencer and a revolution counter.

---
 rtl/stepper_phase_driver.sv | 189 ++++++++++++++++++
 tb/tb_stepper_phase_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_driver.sv
// Stepper coil phase driver: synchronizes run/speed/direction inputs and steps the coil sequence at n*10 laps/min.
// Define STEPPER_HALF_STEP_EN for the 8-entry half-step sequence (double steps per revolution, same lap speed).
module stepper_phase_driver #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int STEPS_PER_REV = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] speed_code,
    input  logic       dir,
    output logic [3:0] coil,
    output logic       step_pulse,
    output logic       rev_tick
);

`ifdef STEPPER_HALF_STEP_EN
    localparam int SPR = 2 * STEPS_PER_REV;
    localparam int IW  = 3;
`else
    localparam int SPR = STEPS_PER_REV;
    localparam int IW  = 2;
`endif

    function automatic longint interval(input int n);
        return (longint'(CLK_HZ) * 64'd6) / (longint'(SPR) * longint'(n));
    endfunction

    localparam longint IV1 = interval(1);
    localparam longint IV2 = interval(2);
    localparam longint IV3 = interval(3);
    localparam longint IV4 = interval(4);
    localparam longint IV5 = interval(5);
    localparam longint IV6 = interval(6);
    localparam int     CW  = $clog2(IV1);

    localparam logic [CW-1:0] RL1 = CW'(IV1 - 1);
    localparam logic [CW-1:0] RL2 = CW'(IV2 - 1);
    localparam logic [CW-1:0] RL3 = CW'(IV3 - 1);
    localparam logic [CW-1:0] RL4 = CW'(IV4 - 1);
    localparam logic [CW-1:0] RL5 = CW'(IV5 - 1);
    localparam logic [CW-1:0] RL6 = CW'(IV6 - 1);

    localparam int            RW       = (SPR > 1) ? $clog2(SPR) : 1;
    localparam logic [RW-1:0] REV_LAST = RW'(SPR - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'((1 << IW) - 1);

    generate
        if (IV6 < 2) begin : g_bad_params
            $error("stepper_phase_driver: CLK_HZ/STEPS_PER_REV give a code-6 step interval below 2 cycles");
        end
    endgenerate

    function automatic logic [CW-1:0] reload_val(input logic [2:0] c);
        case (c)
            3'd2:    return RL2;
            3'd3:    return RL3;
            3'd4:    return RL4;
            3'd5:    return RL5;
            3'd6:    return RL6;
            default: return RL1;
        endcase
    endfunction

    function automatic logic [3:0] phase_pattern(input logic [IW-1:0] idx);
`ifdef STEPPER_HALF_STEP_EN
        case (idx)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1100;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0010;
            3'd5:    return 4'b0011;
            3'd6:    return 4'b0001;
            default: return 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    return 4'b1100;
            2'd1:    return 4'b0110;
            2'd2:    return 4'b0011;
            default: return 4'b1001;
        endcase
`endif
    endfunction

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    logic          r_en_p0, r_en_p1;
    logic [2:0]    r_code_p0, r_code_p1;
    logic          r_dir_p0, r_dir_p1;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_cur, w_cnt_nxt;
    logic          r_code_zero;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [RW-1:0] r_rev, w_rev_nxt;
    logic [3:0]    r_coil, w_coil_nxt;
    logic          r_step, w_step;
    logic          r_rev_tick, w_rev_tick;
    logic [2:0]    w_code;

    // Stage p0/p1: two-flop synchronizers for the asynchronous controls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_p0   <= 1'b0;
            r_en_p1   <= 1'b0;
            r_code_p0 <= 3'd0;
            r_code_p1 <= 3'd0;
            r_dir_p0  <= 1'b0;
            r_dir_p1  <= 1'b0;
        end else begin
            r_en_p0   <= enable;
            r_en_p1   <= r_en_p0;
            r_code_p0 <= speed_code;
            r_code_p1 <= r_code_p0;
            r_dir_p0  <= dir;
            r_dir_p1  <= r_dir_p0;
        end
    end

    assign w_code = (r_code_p1 == 3'd7) ? 3'd6 : r_code_p1;

    // After a stopped (code 0) cycle the count restarts from the new code's reload value
    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_rev_tick  = 1'b0;
        w_cnt_cur   = r_code_zero ? reload_val(w_code) : r_cnt;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rev_nxt   = r_rev;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = reload_val(w_code);
                if (r_en_p1) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_code == 3'd0) begin
                    w_cnt_nxt = reload_val(w_code);
                end else if (w_cnt_cur == '0) begin
                    w_step    = 1'b1;
                    w_cnt_nxt = reload_val(w_code);
                    if (r_dir_p1) w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    else          w_idx_nxt = (r_idx == '0) ? LAST_IDX : r_idx - 1'b1;
                    if (r_rev == REV_LAST) begin
                        w_rev_nxt  = '0;
                        w_rev_tick = 1'b1;
                    end else begin
                        w_rev_nxt = r_rev + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_cur - 1'b1;
                end
                if (!r_en_p1) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_coil_nxt = (w_state_nxt == ST_RUN) ? phase_pattern(w_idx_nxt) : 4'b0000;
    end

    // Stage p2: state, sequencer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= RL1;
            r_code_zero <= 1'b0;
            r_idx       <= '0;
            r_rev       <= '0;
            r_coil      <= 4'b0000;
            r_step      <= 1'b0;
            r_rev_tick  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_code_zero <= (w_code == 3'd0);
            r_idx       <= w_idx_nxt;
            r_rev       <= w_rev_nxt;
            r_coil      <= w_coil_nxt;
            r_step      <= w_step;
            r_rev_tick  <= w_rev_tick;
        end
    end

    assign coil       = r_coil;
    assign step_pulse = r_step;
    assign rev_tick   = r_rev_tick;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Scoreboard bench for stepper_phase_driver: a next-step-time reference model predicts every cycle's outputs.
module tb_stepper_phase_driver;

    localparam int TB_CLK_HZ = 240;
    localparam int TB_SPRB   = 4;
`ifdef STEPPER_HALF_STEP_EN
    localparam int SPR = 2 * TB_SPRB;
    localparam int NPH = 8;
    localparam logic [3:0] SEQ [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
    localparam int SPR = TB_SPRB;
    localparam int NPH = 4;
    localparam logic [3:0] SEQ [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] speed_code = 3'd0;
    logic       dir = 1'b0;
    logic [3:0] coil;
    logic       step_pulse;
    logic       rev_tick;

    stepper_phase_driver #(
        .CLK_HZ       (TB_CLK_HZ),
        .STEPS_PER_REV(TB_SPRB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .speed_code(speed_code),
        .dir       (dir),
        .coil      (coil),
        .step_pulse(step_pulse),
        .rev_tick  (rev_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] coil;
        logic       step;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_steps = 0;
    int   model_steps = 0;

    function automatic int iv(input int c);
        return (TB_CLK_HZ * 6) / (SPR * c);
    endfunction

    // Reference model: inputs reach the logic two edges after they are driven;
    // a running motor is described by the edge number of its next step.
    int         edge_n = 0;
    bit         h_en0, h_en1, h_dir0, h_dir1;
    int         h_code0, h_code1;
    bit         m_run;
    int         m_next;
    int         m_idx;
    int         m_rev;

    always @(posedge clk) begin
        exp_t e;
        bit   s_en, s_dir, stepped, ticked;
        int   c;
        edge_n++;
        stepped = 1'b0;
        ticked  = 1'b0;
        if (reset) begin
            h_en0 = 0; h_en1 = 0; h_dir0 = 0; h_dir1 = 0; h_code0 = 0; h_code1 = 0;
            m_run = 0; m_next = -1; m_idx = 0; m_rev = 0;
        end else begin
            s_en  = h_en1;
            s_dir = h_dir1;
            c     = (h_code1 == 7) ? 6 : h_code1;
            h_en1 = h_en0;   h_en0 = enable;
            h_dir1 = h_dir0; h_dir0 = dir;
            h_code1 = h_code0; h_code0 = int'(speed_code);
            if (!m_run) begin
                if (s_en) begin
                    m_run  = 1;
                    m_next = (c == 0) ? -1 : edge_n + iv(c);
                end
            end else begin
                if (c == 0) begin
                    m_next = -1;
                end else begin
                    if (m_next < 0) m_next = edge_n - 1 + iv(c);
                    if (m_next == edge_n) begin
                        stepped = 1'b1;
                        model_steps++;
                        m_idx  = (m_idx + (s_dir ? 1 : NPH - 1)) % NPH;
                        m_rev  = (m_rev + 1) % SPR;
                        ticked = (m_rev == 0);
                        m_next = edge_n + iv(c);
                    end
                end
                if (!s_en) m_run = 0;
            end
        end
        e.coil = m_run ? SEQ[m_idx] : 4'b0000;
        e.step = stepped;
        e.tick = ticked;
        exp_q.push_back(e);
    end

    // Monitor: compare the DUT's registered outputs against the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (step_pulse === 1'b1) dut_steps++;
            checks++;
            if (coil !== e.coil || step_pulse !== e.step || rev_tick !== e.tick) begin
                errors++;
                $display("FAIL cycle %0d: coil/step/tick got %b/%b/%b expected %b/%b/%b",
                         edge_n, coil, step_pulse, rev_tick, e.coil, e.step, e.tick);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        run(3);
        reset = 1'b0; enable = 1'b1; speed_code = 3'd1; dir = 1'b1;
        run(3 + 4 * 360 + 10);
        speed_code = 3'd6; dir = 1'b0;
        run(200);
        speed_code = 3'd1;
        run(150);
        speed_code = 3'd2;
        run(700);
        speed_code = 3'd7;
        run(200);
        speed_code = 3'd0;
        run(1000);
        speed_code = 3'd3;
        run(300);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(200);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(60);
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                run(1);
                reset = 1'b0;
            end
            enable     = ($urandom_range(0, 5) != 0);
            speed_code = 3'($urandom_range(0, 7));
            dir        = 1'($urandom_range(0, 1));
            run($urandom_range(10, 500));
        end
        run(3);
        checks++;
        if (dut_steps != model_steps) begin
            errors++;
            $display("FAIL step_count: got %0d expected %0d", dut_steps, model_steps);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
